hazard_forward_unit: RTL and testbench

- Pipeline control companion to the 5-stage MIPS datapath.
- Sits alongside IF/ID/EX and drives the datapath's hazard inputs: forwardA, forwardB, stall_needed, pcWrite, ifidWrite, ifidFlush, pcSrc, jORb.
- Keeps its own shadow pipeline of destination and operand tags for EX/MEM/WB. Decides forwarding, load-use and branch-operand stalls, and taken-branch/jump redirects with IF/ID flush.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_forward_pkg.sv | 34 +++
 rtl/hazard_sat_counter.sv | 31 +++
 rtl/hazard_forward_unit.sv | 180 ++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_pkg.sv
// Shared definitions for the hazard/forwarding control block.
// Holds the datapath mux encodings, the per-cycle control decision
// type and a helper that picks a forwarding source.
package hazard_forward_pkg;

    localparam int REG_W = 5;

    // ALU operand select encodings
    localparam logic [2:0] FWD_IDEX = 3'd0;
    localparam logic [2:0] FWD_WB   = 3'd1;
    localparam logic [2:0] FWD_MEM  = 3'd2;

    // PC source / target select encodings
    localparam logic PCSRC_SEQ = 1'b1;
    localparam logic PCSRC_TGT = 1'b0;
    localparam logic JORB_BR   = 1'b1;
    localparam logic JORB_J    = 1'b0;

    // What the front end does this cycle
    typedef enum logic [1:0] {
        CTL_RUN,
        CTL_STALL,
        CTL_JUMP,
        CTL_BRANCH
    } ctl_kind_e;

    // MEM is the younger producer, so it wins over WB.
    function automatic logic [2:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_IDEX;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low clear
//   en    - count one event this cycle
//   count - current value, holds at all-ones
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
// Tracks a shadow copy of EX/MEM/WB register tags and drives the
// datapath's forward selects, stall/bubble, PC/IF-ID enables and
// redirect controls. Two saturating counters record stalls and redirects.
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   id_rs/id_rt/id_uses_*      - source operands of the ID instruction
//   id_dst/id_regWrite         - destination of the ID instruction
//   id_memRead/id_branch/id_jump - ID instruction kind
//   regs_equal                 - ID comparator result for beq
//   forwardA/forwardB          - ALU operand selects (2=MEM, 1=WB, 0=ID/EX)
//   stall_needed, pcWrite, ifidWrite, ifidFlush, pcSrc, jORb - front-end control
//   stall_count, flush_count   - saturating event counters
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             regs_equal,
    output logic [2:0]       forwardA,
    output logic [2:0]       forwardB,
    output logic             stall_needed,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             pcSrc,
    output logic             jORb,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    import hazard_forward_pkg::*;

    // Shadow pipeline. Only the fields that a later check reads are kept.
    logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dst_q, ex_dst_d;
    logic             ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d;
    logic [REG_W-1:0] mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
    logic             mem_rw_q, mem_rw_d, wb_rw_q, wb_rw_d;

    logic        id_wr;
    logic        load_use, pend_rs, pend_rt, br_haz;
    logic [2:0]  fwd_a, fwd_b;
    ctl_kind_e   kind;

    // A write to $0 is architecturally a no-op, so it is never a producer.
    assign id_wr = id_regWrite && (id_dst != '0);

    // rw bits are only set for non-zero destinations, so a tag match
    // with a set rw bit already excludes $0.
    assign fwd_a = fwd_sel(mem_rw_q && (mem_dst_q == ex_rs_q),
                           wb_rw_q  && (wb_dst_q  == ex_rs_q));
    assign fwd_b = fwd_sel(mem_rw_q && (mem_dst_q == ex_rt_q),
                           wb_rw_q  && (wb_dst_q  == ex_rt_q));

    assign load_use = ex_mr_q && (ex_dst_q != '0) &&
                      ((id_uses_rs && (id_rs == ex_dst_q)) ||
                       (id_uses_rt && (id_rt == ex_dst_q)));

    // The ID comparator reads the register file only, so any in-flight
    // producer of a branch operand, including one in WB, blocks the branch.
    assign pend_rs = (ex_rw_q  && (ex_dst_q  == id_rs)) ||
                     (mem_rw_q && (mem_dst_q == id_rs)) ||
                     (wb_rw_q  && (wb_dst_q  == id_rs));
    assign pend_rt = (ex_rw_q  && (ex_dst_q  == id_rt)) ||
                     (mem_rw_q && (mem_dst_q == id_rt)) ||
                     (wb_rw_q  && (wb_dst_q  == id_rt));
    assign br_haz  = id_branch && ((id_uses_rs && pend_rs) || (id_uses_rt && pend_rt));

    always_comb begin
        kind = CTL_RUN;
        if (load_use || br_haz)          kind = CTL_STALL;
        else if (id_jump)                kind = CTL_JUMP;
        else if (id_branch && regs_equal) kind = CTL_BRANCH;
    end

    // Outputs are forced to their safe values while reset is held.
    always_comb begin
        forwardA     = FWD_IDEX;
        forwardB     = FWD_IDEX;
        stall_needed = 1'b1;
        pcWrite      = 1'b0;
        ifidWrite    = 1'b0;
        ifidFlush    = 1'b1;
        pcSrc        = PCSRC_SEQ;
        jORb         = JORB_BR;
        if (rst) begin
            forwardA     = fwd_a;
            forwardB     = fwd_b;
            stall_needed = 1'b0;
            pcWrite      = 1'b1;
            ifidWrite    = 1'b1;
            ifidFlush    = 1'b0;
            case (kind)
                CTL_STALL: begin
                    stall_needed = 1'b1;
                    pcWrite      = 1'b0;
                    ifidWrite    = 1'b0;
                end
                CTL_JUMP: begin
                    pcSrc     = PCSRC_TGT;
                    jORb      = JORB_J;
                    ifidFlush = 1'b1;
                end
                CTL_BRANCH: begin
                    pcSrc     = PCSRC_TGT;
                    ifidFlush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // EX takes a bubble on a stall, matching the zeroed ID/EX bundle.
    always_comb begin
        ex_rs_d   = id_uses_rs ? id_rs : '0;
        ex_rt_d   = id_uses_rt ? id_rt : '0;
        ex_dst_d  = id_dst;
        ex_rw_d   = id_wr;
        ex_mr_d   = id_memRead;
        if (kind == CTL_STALL) begin
            ex_rs_d  = '0;
            ex_rt_d  = '0;
            ex_dst_d = '0;
            ex_rw_d  = 1'b0;
            ex_mr_d  = 1'b0;
        end
        mem_dst_d = ex_dst_q;
        mem_rw_d  = ex_rw_q;
        wb_dst_d  = mem_dst_q;
        wb_rw_d   = mem_rw_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_rs_q   <= '0;
            ex_rt_q   <= '0;
            ex_dst_q  <= '0;
            ex_rw_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            mem_dst_q <= '0;
            mem_rw_q  <= 1'b0;
            wb_dst_q  <= '0;
            wb_rw_q   <= 1'b0;
        end else begin
            ex_rs_q   <= ex_rs_d;
            ex_rt_q   <= ex_rt_d;
            ex_dst_q  <= ex_dst_d;
            ex_rw_q   <= ex_rw_d;
            ex_mr_q   <= ex_mr_d;
            mem_dst_q <= mem_dst_d;
            mem_rw_q  <= mem_rw_d;
            wb_dst_q  <= wb_dst_d;
            wb_rw_q   <= wb_rw_d;
        end
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (kind == CTL_STALL),
        .count (stall_count)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    ((kind == CTL_JUMP) || (kind == CTL_BRANCH)),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a cycle-by-cycle vector table
// for the instruction sequences, plus hand-written reset and
// counter-saturation sequences. Counters use an 8-bit width so the
// saturation run stays short.
module tb_hazard_forward_unit;

    localparam int RW = 5;
    localparam int CW = 8;

    // control bundle {stall_needed, pcWrite, ifidWrite, ifidFlush, pcSrc, jORb}
    localparam logic [5:0] C_RUN = 6'b011011;
    localparam logic [5:0] C_STL = 6'b100011;
    localparam logic [5:0] C_BR  = 6'b011101;
    localparam logic [5:0] C_J   = 6'b011100;
    localparam logic [5:0] C_RST = 6'b100111;

    logic          clk, rst;
    logic [RW-1:0] id_rs, id_rt, id_dst;
    logic          id_uses_rs, id_uses_rt, id_regWrite, id_memRead;
    logic          id_branch, id_jump, regs_equal;
    logic [2:0]    forwardA, forwardB;
    logic          stall_needed, pcWrite, ifidWrite, ifidFlush, pcSrc, jORb;
    logic [CW-1:0] stall_count, flush_count;

    hazard_forward_unit #(.REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_branch(id_branch), .id_jump(id_jump), .regs_equal(regs_equal),
        .forwardA(forwardA), .forwardB(forwardB), .stall_needed(stall_needed),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .pcSrc(pcSrc), .jORb(jORb), .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] rs, rt;
        logic          urs, urt;
        logic [RW-1:0] dst;
        logic          rw, mr, br, jmp, eq;
        logic [2:0]    fa, fb;
        logic [5:0]    ctl;
        int            sc, fc;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic v(input int rs, input int rt, input bit urs, input bit urt,
                     input int dst, input bit rw, input bit mr, input bit br,
                     input bit jmp, input bit eq, input int fa, input int fb,
                     input logic [5:0] ctl, input int sc, input int fc);
        vec_t e;
        e.rs = RW'(rs); e.rt = RW'(rt); e.urs = urs; e.urt = urt;
        e.dst = RW'(dst); e.rw = rw; e.mr = mr; e.br = br; e.jmp = jmp; e.eq = eq;
        e.fa = 3'(fa); e.fb = 3'(fb); e.ctl = ctl; e.sc = sc; e.fc = fc;
        vq.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic drive(input vec_t e);
        id_rs = e.rs; id_rt = e.rt; id_uses_rs = e.urs; id_uses_rt = e.urt;
        id_dst = e.dst; id_regWrite = e.rw; id_memRead = e.mr;
        id_branch = e.br; id_jump = e.jmp; regs_equal = e.eq;
    endtask

    function automatic logic [5:0] ctl_now();
        return {stall_needed, pcWrite, ifidWrite, ifidFlush, pcSrc, jORb};
    endfunction

    vec_t nop, rd9, brw;

    initial begin
        nop = '{default: '0};
        rst = 1'b0;
        drive(nop);

        // ---- reset state
        @(negedge clk); @(negedge clk); #1;
        chk("reset_ctl", int'(ctl_now()), int'(C_RST));
        chk("reset_fwd", int'({forwardA, forwardB}), 0);
        chk("reset_cnt", int'({stall_count, flush_count}), 0);
        @(negedge clk);
        rst = 1'b1;

        // ---- instruction-sequence table (ID contents per cycle, expected outputs)
        //   rs rt urs urt dst rw mr br j eq   fA fB ctl    sc fc
        v(1, 2, 1, 1, 3, 1, 0, 0, 0, 0,  0, 0, C_RUN, 0, 0); // add $3,$1,$2
        v(3, 5, 1, 1, 4, 1, 0, 0, 0, 0,  0, 0, C_RUN, 0, 0); // sub $4,$3,$5
        v(3, 7, 1, 1, 6, 1, 0, 0, 0, 0,  2, 0, C_RUN, 0, 0); // or $6,$3,$7 ; sub in EX
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, C_RUN, 0, 0); // or in EX, add in WB
        v(1, 3, 1, 0, 3, 1, 1, 0, 0, 0,  0, 0, C_RUN, 0, 0); // lw $3,0($1)
        v(3, 3, 1, 1, 4, 1, 0, 0, 0, 0,  0, 0, C_STL, 0, 0); // add $4,$3,$3 load-use
        v(3, 3, 1, 1, 4, 1, 0, 0, 0, 0,  0, 0, C_RUN, 1, 0); // add re-issued
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, C_RUN, 1, 0); // add in EX, lw in WB
        v(1, 2, 1, 1, 3, 1, 0, 0, 0, 0,  0, 0, C_RUN, 1, 0); // add $3,$1,$2
        v(3, 0, 1, 1, 0, 0, 0, 1, 0, 1,  0, 0, C_STL, 1, 0); // beq $3,$0 producer EX
        v(3, 0, 1, 1, 0, 0, 0, 1, 0, 1,  0, 0, C_STL, 2, 0); // producer MEM
        v(3, 0, 1, 1, 0, 0, 0, 1, 0, 1,  0, 0, C_STL, 3, 0); // producer WB
        v(3, 0, 1, 1, 0, 0, 0, 1, 0, 1,  0, 0, C_BR,  4, 0); // branch taken
        v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, C_J,   4, 1); // j
        v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0, C_J,   4, 2); // j and taken beq: jump wins
        v(1, 0, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, C_RUN, 4, 3); // lw $0,0($1)
        v(0, 0, 1, 1, 0, 0, 0, 1, 0, 0,  0, 0, C_RUN, 4, 3); // beq $0,$0 behind lw $0
        v(0, 0, 1, 1, 5, 1, 0, 0, 0, 0,  0, 0, C_RUN, 4, 3); // add $5,$0,$0
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, C_RUN, 4, 3); // add $5 in EX, lw $0 in WB
        v(1, 0, 1, 0, 7, 1, 0, 0, 0, 0,  0, 0, C_RUN, 4, 3); // addi $7,$1
        v(2, 0, 1, 0, 7, 1, 0, 0, 0, 0,  0, 0, C_RUN, 4, 3); // addi $7,$2
        v(7, 7, 1, 1, 8, 1, 0, 0, 0, 0,  0, 0, C_RUN, 4, 3); // add $8,$7,$7
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 2, C_RUN, 4, 3); // MEM beats WB

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk($sformatf("v%0d_fwdA", i), int'(forwardA), int'(vq[i].fa));
            chk($sformatf("v%0d_fwdB", i), int'(forwardB), int'(vq[i].fb));
            chk($sformatf("v%0d_ctl", i), int'(ctl_now()), int'(vq[i].ctl));
            chk($sformatf("v%0d_stall_cnt", i), int'(stall_count), vq[i].sc);
            chk($sformatf("v%0d_flush_cnt", i), int'(flush_count), vq[i].fc);
        end

        // ---- reset asserted in the middle of a load-use stall
        @(negedge clk);
        drive(nop);
        id_rs = 5'd1; id_uses_rs = 1'b1; id_dst = 5'd9; id_regWrite = 1'b1; id_memRead = 1'b1;
        rd9 = nop;
        rd9.rs = 5'd9; rd9.rt = 5'd9; rd9.urs = 1'b1; rd9.urt = 1'b1; rd9.dst = 5'd10; rd9.rw = 1'b1;
        @(negedge clk);
        drive(rd9);
        #1;
        chk("midrst_pre_stall", int'(ctl_now()), int'(C_STL));
        rst = 1'b0;
        #1;
        chk("midrst_ctl", int'(ctl_now()), int'(C_RST));
        chk("midrst_fwd", int'({forwardA, forwardB}), 0);
        chk("midrst_cnt", int'({stall_count, flush_count}), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("postrst_ctl", int'(ctl_now()), int'(C_RUN));
        chk("postrst_cnt", int'({stall_count, flush_count}), 0);
        @(negedge clk); #1;
        chk("postrst_next_cnt", int'(stall_count), 0);

        // ---- counter saturation: a branch that also writes its own
        // operand stalls 3 of every 4 cycles
        rst = 1'b0;
        @(negedge clk);
        brw = nop;
        brw.rs = 5'd3; brw.urs = 1'b1; brw.dst = 5'd3; brw.rw = 1'b1; brw.br = 1'b1;
        drive(brw);
        rst = 1'b1;
        for (int c = 0; c < 348; c++) begin
            #1;
            if (c == 40) chk("sat_mid_stall_cnt", int'(stall_count), 30);
            if (c == 1)  chk("sat_first_stall", int'(stall_needed), 1);
            if (c == 4)  chk("sat_gap_run", int'(stall_needed), 0);
            @(negedge clk);
        end
        #1;
        chk("sat_stall_cnt", int'(stall_count), 255);
        chk("sat_flush_cnt", int'(flush_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
